// File: rtl/maquina_pkg.sv
// maquina_pkg: shared state encoding and constants for the vending sequencer
package maquina_pkg;
  typedef enum logic [2:0] {IDLE, VEND, GAP_V, CHANGE, GAP_C} state_t;
  localparam int COIN_N_VAL = 1;
  localparam int COIN_D_VAL = 2;
  localparam int PRICE_N_DEF = 3;
  localparam int CREDIT_MAX_DEF = 6;
endpackage

// File: rtl/maquina_edge_sync.sv
// maquina_edge_sync: 2-FF synchronizer plus registered rising-edge detector
// Ports: clk, rst (async, active high), din (raw level), evt (1-cycle event, 3 cycles after din rises)
module maquina_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);
  logic [2:0] sh;
  logic [2:0] vld;
  // vld masks edges until the history stage holds a real sample, so a level
  // already high when reset releases is not mistaken for a fresh edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      vld <= '0;
      evt <= 1'b0;
    end else begin
      sh <= {sh[1:0], din};
      vld <= {vld[1:0], 1'b1};
      evt <= sh[1] & ~sh[2] & vld[2];
    end
endmodule

// File: rtl/maquina_vend_seq.sv
// maquina_vend_seq: vending credit counter and serialized product/change pulse sequencer
// Ports: clk, rst (async, active high); coin_n_i, coin_d_i, buy_i, refund_i (raw levels);
//        prod_o, nickel_o (actuator pulses), ret_o (change/refund in progress),
//        reject_o (1-cycle coin reject), busy_o (not IDLE), credit_o (nickels held)
module maquina_vend_seq
  import maquina_pkg::*;
#(
  parameter int PRICE_N = PRICE_N_DEF,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_n_i,
  input  logic       coin_d_i,
  input  logic       buy_i,
  input  logic       refund_i,
  output logic       prod_o,
  output logic       nickel_o,
  output logic       ret_o,
  output logic       reject_o,
  output logic       busy_o,
  output logic [2:0] credit_o
);
  localparam int TW = $clog2((PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC) + 1);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] T_GAP = TW'(GAP_CYC - 1);
  localparam logic [3:0] CMAX = 4'(CREDIT_MAX);
  localparam logic [2:0] PRICE = 3'(PRICE_N);
  state_t state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [2:0] credit_nxt;
  logic rej_nxt, ev_n, ev_d, ev_b, ev_r, coin_ev, tmr_done;
  logic [1:0] coin;
  logic [3:0] sum;
  maquina_edge_sync u_sync_n (.clk(clk), .rst(rst), .din(coin_n_i), .evt(ev_n));
  maquina_edge_sync u_sync_d (.clk(clk), .rst(rst), .din(coin_d_i), .evt(ev_d));
  maquina_edge_sync u_sync_b (.clk(clk), .rst(rst), .din(buy_i), .evt(ev_b));
  maquina_edge_sync u_sync_r (.clk(clk), .rst(rst), .din(refund_i), .evt(ev_r));
  assign coin = (ev_n ? 2'(COIN_N_VAL) : 2'd0) + (ev_d ? 2'(COIN_D_VAL) : 2'd0);
  assign coin_ev = ev_n | ev_d;
  assign sum = {1'b0, credit_o} + {2'b0, coin};
  assign tmr_done = tmr == '0;
  always_comb begin
    state_nxt = state;
    credit_nxt = credit_o;
    rej_nxt = 1'b0;
    case (state)
      IDLE:
        if (coin_ev) begin
          rej_nxt = sum > CMAX;
          credit_nxt = sum > CMAX ? credit_o : sum[2:0];
        end else if (ev_b && credit_o >= PRICE) begin
          credit_nxt = credit_o - PRICE;
          state_nxt = VEND;
        end else if (ev_r && credit_o != 3'd0)
          state_nxt = CHANGE;
      VEND:   state_nxt = tmr_done ? GAP_V : VEND;
      GAP_V:  state_nxt = !tmr_done ? GAP_V : credit_o != 3'd0 ? CHANGE : IDLE;
      CHANGE:
        if (tmr_done) begin
          state_nxt = GAP_C;
          credit_nxt = credit_o - 3'd1;
        end
      GAP_C:  state_nxt = !tmr_done ? GAP_C : credit_o != 3'd0 ? CHANGE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && coin_ev) rej_nxt = 1'b1;
    // one shared timer, reloaded whenever a new state is entered
    tmr_nxt = state_nxt != state ? (state_nxt inside {VEND, CHANGE} ? T_PULSE : T_GAP)
                                 : (tmr_done ? tmr : tmr - 1'b1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      credit_o <= '0;
      prod_o <= 1'b0;
      nickel_o <= 1'b0;
      ret_o <= 1'b0;
      reject_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr <= tmr_nxt;
      credit_o <= credit_nxt;
      reject_o <= rej_nxt;
      prod_o <= state_nxt == VEND;
      nickel_o <= state_nxt == CHANGE;
      ret_o <= state_nxt inside {CHANGE, GAP_C};
      busy_o <= state_nxt != IDLE;
    end
endmodule

// File: tb/tb_maquina_vend_seq.sv
// tb_maquina_vend_seq: scoreboard bench with a transaction-level credit model
module tb_maquina_vend_seq;
  localparam int PRICE = 3, CMAX = 6, PULSE = 4, GAP = 2;
  localparam int K_CREDIT = 0, K_PROD = 1, K_NICK = 2, K_IDLE = 3, K_REJ = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic coin_n_i = 1'b0, coin_d_i = 1'b0, buy_i = 1'b0, refund_i = 1'b0;
  logic prod_o, nickel_o, ret_o, reject_o, busy_o;
  logic [2:0] credit_o;
  always #5 clk = ~clk;
  maquina_vend_seq dut (
    .clk(clk), .rst(rst), .coin_n_i(coin_n_i), .coin_d_i(coin_d_i), .buy_i(buy_i),
    .refund_i(refund_i), .prod_o(prod_o), .nickel_o(nickel_o), .ret_o(ret_o),
    .reject_o(reject_o), .busy_o(busy_o), .credit_o(credit_o)
  );
  // v = length/value, w = preceding gap (-1 first pulse of a busy period), x = ret_o anomalies
  typedef struct {int k; int v; int w; int x;} ev_t;
  ev_t exp_q[$];
  ev_t rej_q[$];
  int tests = 0, fails = 0, m_credit = 0;
  function automatic ev_t mk(int k, int v, int w, int x);
    ev_t e;
    e.k = k; e.v = v; e.w = w; e.x = x;
    return e;
  endfunction
  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic got(ev_t e);
    ev_t x;
    if ((e.k == K_REJ ? rej_q.size() : exp_q.size()) == 0) begin
      tests++; fails++;
      $display("FAIL unexpected event kind=%0d v=%0d w=%0d x=%0d at %0t", e.k, e.v, e.w, e.x, $time);
    end else begin
      x = e.k == K_REJ ? rej_q.pop_front() : exp_q.pop_front();
      chk("event_kind", e.k, x.k);
      chk($sformatf("kind%0d_value", x.k), e.v, x.v);
      chk($sformatf("kind%0d_gap", x.k), e.w, x.w);
      chk($sformatf("kind%0d_ret", x.k), e.x, x.x);
    end
  endtask
  // monitor: turns output waveforms into events and checks them against the queues
  int p_len = 0, n_len = 0, p_gap = 0, n_gap = 0, px = 0, nx = 0, since = 0, r_len = 0, prev_credit = 0;
  bit first = 1'b1, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      p_len = 0; n_len = 0; since = 0; r_len = 0; first = 1'b1; prev_busy = 1'b0; prev_credit = 0;
    end else begin
      if (p_len > 0 && !prod_o) begin got(mk(K_PROD, p_len, p_gap, px)); p_len = 0; end
      if (n_len > 0 && !nickel_o) begin got(mk(K_NICK, n_len, n_gap, nx)); n_len = 0; end
      if (prod_o && nickel_o) begin
        tests++; fails++;
        $display("FAIL actuator_overlap: prod_o=1 nickel_o=1 required not both at %0t", $time);
      end
      if (prod_o) begin
        if (p_len == 0) begin p_gap = first ? -1 : since; first = 1'b0; since = 0; px = 0; end
        p_len++;
        if (ret_o) px++;
      end
      if (nickel_o) begin
        if (n_len == 0) begin n_gap = first ? -1 : since; first = 1'b0; since = 0; nx = 0; end
        n_len++;
        if (!ret_o) nx++;
      end
      if (busy_o && !prod_o && !nickel_o) since++;
      if (int'(credit_o) != prev_credit) got(mk(K_CREDIT, int'(credit_o), 0, 0));
      prev_credit = int'(credit_o);
      if (reject_o) r_len++;
      else if (r_len > 0) begin got(mk(K_REJ, r_len, 0, 0)); r_len = 0; end
      if (prev_busy && !busy_o) begin got(mk(K_IDLE, since, 0, int'(ret_o))); since = 0; first = 1'b1; end
      prev_busy = busy_o;
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic settle();
    int t = 0;
    tick(6);
    while (busy_o && t < 300) begin tick(1); t++; end
    if (busy_o) begin
      tests++; fails++;
      $display("FAIL settle_timeout: busy_o=1 required 0 within 300 cycles");
    end
    tick(3);
  endtask
  task automatic push_change(int g0);
    int g = g0;
    while (m_credit > 0) begin
      exp_q.push_back(mk(K_NICK, PULSE, g, 0));
      m_credit--;
      exp_q.push_back(mk(K_CREDIT, m_credit, 0, 0));
      g = GAP;
    end
    exp_q.push_back(mk(K_IDLE, GAP, 0, 0));
  endtask
  task automatic model(bit n, bit d, bit b, bit r);
    int c = (n ? 1 : 0) + (d ? 2 : 0);
    if (c > 0) begin
      if (m_credit + c > CMAX) rej_q.push_back(mk(K_REJ, 1, 0, 0));
      else begin m_credit += c; exp_q.push_back(mk(K_CREDIT, m_credit, 0, 0)); end
    end else if (b && m_credit >= PRICE) begin
      m_credit -= PRICE;
      exp_q.push_back(mk(K_CREDIT, m_credit, 0, 0));
      exp_q.push_back(mk(K_PROD, PULSE, -1, 0));
      push_change(GAP);
    end else if (r && m_credit > 0) push_change(-1);
  endtask
  task automatic act(bit n, bit d, bit b, bit r, int hold);
    model(n, d, b, r);
    coin_n_i = n; coin_d_i = d; buy_i = b; refund_i = r;
    tick(hold);
    coin_n_i = 0; coin_d_i = 0; buy_i = 0; refund_i = 0;
    tick(1);
    settle();
  endtask
  task automatic vend_with_dime();
    model(0, 0, 1, 0);
    rej_q.push_back(mk(K_REJ, 1, 0, 0));
    buy_i = 1;
    tick(2);
    coin_d_i = 1;
    tick(2);
    buy_i = 0; coin_d_i = 0;
    tick(1);
    settle();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat;
    tick(3);
    chk("reset_credit", int'(credit_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_prod", int'(prod_o), 0);
    rst = 0;
    tick(4);
    repeat (3) act(1, 0, 0, 0, 1);
    model(0, 0, 1, 0);
    buy_i = 1; lat = 0;
    do begin tick(1); lat++; end while (!prod_o && lat < 20);
    chk("buy_pin_to_prod_latency", lat, 4);
    buy_i = 0;
    settle();
    repeat (2) act(0, 1, 0, 0, 2);
    act(0, 0, 1, 0, 1);
    repeat (2) act(1, 0, 0, 0, 3);
    act(0, 0, 1, 0, 2);
    chk("unaffordable_busy", int'(busy_o), 0);
    chk("unaffordable_credit", int'(credit_o), 2);
    act(1, 0, 0, 0, 1);
    act(0, 0, 0, 1, 1);
    repeat (3) act(0, 1, 0, 0, 1);
    act(1, 0, 0, 0, 1);
    act(0, 0, 1, 0, 1);
    act(0, 1, 0, 0, 1); act(0, 1, 0, 0, 1); act(1, 0, 0, 0, 1);
    act(1, 1, 0, 0, 2);
    vend_with_dime();
    repeat (3) act(1, 0, 0, 0, 1);
    exp_q.push_back(mk(K_CREDIT, 0, 0, 0));
    m_credit = 0;
    buy_i = 1; lat = 0;
    do begin tick(1); lat++; end while (!prod_o && lat < 20);
    chk("reset_test_prod_started", int'(prod_o), 1);
    @(posedge clk);
    #2 rst = 1; coin_n_i = 1;
    #1;
    chk("midvend_reset_prod", int'(prod_o), 0);
    chk("midvend_reset_busy", int'(busy_o), 0);
    chk("midvend_reset_credit", int'(credit_o), 0);
    tick(2);
    rst = 0;
    tick(10);
    chk("held_inputs_credit", int'(credit_o), 0);
    chk("held_inputs_busy", int'(busy_o), 0);
    buy_i = 0; coin_n_i = 0;
    tick(3);
    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(0, 11);
      int hold = $urandom_range(1, 4);
      if (sel <= 3) act(1, 0, 0, 0, hold);
      else if (sel <= 5) act(0, 1, 0, 0, hold);
      else if (sel == 6) act(1, 1, 0, 0, hold);
      else if (sel == 7) act(0, 0, 1, 0, hold);
      else if (sel == 8) act(0, 0, 0, 1, hold);
      else if (sel == 9) act(0, 0, 1, 1, hold);
      else if (sel == 10) act(1, 0, 1, 0, hold);
      else if (m_credit >= PRICE) vend_with_dime();
      else act(0, 0, 0, 1, hold);
    end
    tick(5);
    chk("expected_events_left", exp_q.size(), 0);
    chk("expected_rejects_left", rej_q.size(), 0);
    chk("final_credit", int'(credit_o), m_credit);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/maquina_vend_seq.md
Name: maquina_vend_seq

Overview:
Sequencing controller for the vending machine.
- Accepts synchronized coin, buy and refund requests.
- Keeps a credit counter in nickel units.
- Drives timed actuator pulses for product dispense and nickel change.
- Serializes the pulses so only one actuator is active at a time.
- Sits between the top-level switch inputs and the LED/actuator outputs of the machine top.

Parameters:
- PRICE_N, 3, product price in nickel units (3 = 15c).
- CREDIT_MAX, 6, maximum credit in nickel units; a coin that would exceed it is rejected.
- PULSE_CYC, 4, clock cycles each actuator pulse is held high.
- GAP_CYC, 2, idle cycles between consecutive actuator pulses.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- coin_n_i  input  1  nickel sensor, raw level, asynchronous
- coin_d_i  input  1  dime sensor, raw level, asynchronous
- buy_i  input  1  purchase button, raw level
- refund_i  input  1  refund button, raw level
- prod_o  output  1  product actuator pulse
- nickel_o  output  1  change-nickel actuator pulse
- ret_o  output  1  high while returning change or refund
- reject_o  output  1  one-cycle pulse when a coin is rejected
- busy_o  output  1  high in any state other than IDLE
- credit_o  output  3  current credit in nickel units

Behaviour:
Reset
- rst asynchronously clears every output, the credit, the timers and the synchronizers.
- State returns to IDLE.
- Reset mid-VEND or mid-CHANGE aborts immediately; credit is lost and no further pulses are issued.

Input handling
- Each raw input passes through a 2-FF synchronizer, then a rising-edge detector, giving a 1-cycle event.
- Pin-to-event latency: 3 cycles.
- A held level produces exactly one event.

IDLE state
- Coin events: nickel adds 1, dime adds 2.
- Nickel and dime on the same cycle add 3 as a unit.
- If credit plus the coin total exceeds CREDIT_MAX, the whole total is rejected: reject_o pulses for 1 cycle and credit is unchanged.
- On any cycle with a coin event, buy and refund events are ignored.
- Buy event with credit >= PRICE_N: credit -= PRICE_N, go to VEND.
- Buy event with credit < PRICE_N: ignored, no output change.
- Refund event with credit > 0: go to CHANGE with ret_o=1.
- Refund event with credit = 0: ignored.
- Buy and refund on the same cycle: buy takes priority if affordable; otherwise refund is evaluated.

VEND state
- prod_o=1 for PULSE_CYC cycles, then go to GAP_V.

GAP_V state
- All actuators low for GAP_CYC cycles.
- Then go to CHANGE with ret_o=1 if credit > 0, else go to IDLE.

CHANGE state
- nickel_o=1 for PULSE_CYC cycles.
- credit decrements by 1 on the last pulse cycle.
- Then go to GAP_C.

GAP_C state
- All actuators low for GAP_CYC cycles.
- Then go to CHANGE if credit > 0, else go to IDLE with ret_o cleared.

Rules common to all busy states
- Any coin event in a state other than IDLE is rejected (reject_o pulse).
- Buy and refund events are dropped.
- prod_o and nickel_o are never high simultaneously.
- A single down-counter sized $clog2(max(PULSE_CYC,GAP_CYC)+1) serves both pulse and gap timing; it reloads on every state entry.
- credit_o is registered and never wraps: credit never exceeds CREDIT_MAX and never goes below 0.
- All outputs are registered.

Decomposition:
- Package maquina_pkg:
  - state enum {IDLE, VEND, GAP_V, CHANGE, GAP_C}
  - constants COIN_N_VAL=1, COIN_D_VAL=2
  - default PRICE_N and CREDIT_MAX
- Sub-module maquina_edge_sync: 2-FF synchronizer plus rising-edge detect, with the same clk/rst. Instantiate it four times.

Test Plan:
- Three nickel pulses, then buy → credit_o goes 1,2,3; prod_o high exactly 4 cycles starting 1 cycle after the buy event; credit_o=0; no nickel_o; busy_o falls after the 2 gap cycles.
- Two dimes (credit 4), then buy → prod_o 4 cycles, 2-cycle gap, one nickel_o pulse of 4 cycles with ret_o=1, credit_o 4→1→0, then IDLE.
- Credit 2, then buy → no prod_o, credit_o stays 2, busy_o stays 0.
- Credit 3, then refund → three nickel_o pulses of 4 cycles each separated by 2 low cycles; ret_o high throughout; credit_o 3→2→1→0.
- Credit 6, then nickel → reject_o pulses for 1 cycle, credit_o stays 6. Credit 5 with nickel and dime on the same cycle → reject, credit stays 5. Dime inserted during VEND → reject_o pulses.
- Assert rst on the 2nd cycle of prod_o → prod_o, busy_o and credit_o are 0 in the same cycle; after release, held-high inputs generate no spurious events.
